alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 104 ++++++++++
 tb/tb_alu_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit (with package alu_operation)
// Description : Combinational integer ALU with a registered result/flag copy.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package alu_operation;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSX = 4'd10,
        ALU_PASSY = 4'd11
    } alu_operation_t;
endpackage

module alu_unit
    import alu_operation::*;
#(
    parameter int WIDTH = `WORD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  alu_operation_t       op,
    output logic [WIDTH-1:0]     w,
    output logic [WIDTH-1:0]     w_q,
    output logic                 zero_q,
    output logic                 cout_q
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SW-1:0]    shamt;
    logic             carry;
    logic             lt_signed;
    logic             lt_unsigned;

    assign sum         = {1'b0, x} + {1'b0, y};
    assign diff        = {1'b0, x} - {1'b0, y};
    assign shamt       = y[SW-1:0];
    assign lt_signed   = $signed(x) < $signed(y);
    assign lt_unsigned = x < y;

    always_comb begin
        w     = '0;
        carry = 1'b0;
        case (op)
            ALU_ADD: begin
                w     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            ALU_SUB: begin
                w     = diff[WIDTH-1:0];
                // Borrow shows up in the extra bit; report its inverse (x >= y).
                carry = ~diff[WIDTH];
            end
            ALU_AND:   w = x & y;
            ALU_OR:    w = x | y;
            ALU_XOR:   w = x ^ y;
            ALU_SLL:   w = x << shamt;
            ALU_SRL:   w = x >> shamt;
            ALU_SRA:   w = WIDTH'($signed(x) >>> shamt);
            ALU_SLT:   w = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:  w = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_PASSX: w = x;
            ALU_PASSY: w = y;
            default: begin
                w     = '0;
                carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q    <= '0;
            zero_q <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            w_q    <= w;
            zero_q <= (w == '0);
            cout_q <= carry;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Directed self-checking bench for alu_unit.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_alu_unit;
    import alu_operation::*;

    logic                clk;
    logic                rst_n;
    logic [31:0]         x;
    logic [31:0]         y;
    alu_operation_t      op;
    logic [31:0]         w;
    logic [31:0]         w_q;
    logic                zero_q;
    logic                cout_q;

    int passed = 0;
    int total  = 0;

    alu_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .op     (op),
        .w      (w),
        .w_q    (w_q),
        .zero_q (zero_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Apply operands away from the clock edge, then check the combinational result.
    task automatic apply(input alu_operation_t o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] exp_w);
        @(negedge clk);
        op = o;
        x  = a;
        y  = b;
        #1;
        check(tag, w, exp_w);
    endtask

    // After the next rising edge, check the registered copies.
    task automatic regs(input string tag, input logic [31:0] exp_wq,
                        input logic exp_zero, input logic exp_cout);
        @(posedge clk);
        #1;
        check({tag, "_wq"}, w_q, exp_wq);
        check({tag, "_zero"}, {31'd0, zero_q}, {31'd0, exp_zero});
        check({tag, "_cout"}, {31'd0, cout_q}, {31'd0, exp_cout});
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rsum;

    initial begin
        rst_n = 1'b0;
        op    = ALU_ADD;
        x     = 32'd1;
        y     = 32'd1;

        // Reset held over edges: registers clear while w stays live.
        regs("reset", 32'd0, 1'b0, 1'b0);
        regs("reset2", 32'd0, 1'b0, 1'b0);
        check("reset_w", w, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        regs("release", 32'd2, 1'b0, 1'b0);

        // Random ADD, combinational only.
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsum = ra + rb;
            op   = ALU_ADD;
            x    = ra;
            y    = rb;
            #1;
            check("add_rand", w, rsum);
        end

        apply(ALU_ADD, 32'hFFFF_FFFF, 32'd1, "add_wrap", 32'd0);
        regs("add_wrap", 32'd0, 1'b1, 1'b1);

        apply(ALU_SUB, 32'd3, 32'd5, "sub_neg", 32'hFFFF_FFFE);
        regs("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
        apply(ALU_SUB, 32'd5, 32'd3, "sub_pos", 32'd2);
        regs("sub_pos", 32'd2, 1'b0, 1'b1);
        apply(ALU_SUB, 32'd5, 32'd5, "sub_eq", 32'd0);
        regs("sub_eq", 32'd0, 1'b1, 1'b1);

        apply(ALU_SLT,  32'h8000_0000, 32'd1, "slt_neg", 32'd1);
        apply(ALU_SLTU, 32'h8000_0000, 32'd1, "sltu_big", 32'd0);
        apply(ALU_SLT,  32'd1, 32'h8000_0000, "slt_pos", 32'd0);
        apply(ALU_SLTU, 32'd1, 32'h8000_0000, "sltu_small", 32'd1);
        regs("sltu_small", 32'd1, 1'b0, 1'b0);

        apply(ALU_AND, 32'hF0F0_1234, 32'h0FF0_00FF, "and", 32'h00F0_0034);
        apply(ALU_OR,  32'hF0F0_1234, 32'h0FF0_00FF, "or",  32'hFFF0_12FF);
        apply(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_00FF, "xor", 32'hFF00_12CB);

        // Load a carry first so a leaked carry on shifts would show.
        apply(ALU_ADD, 32'hFFFF_FFFF, 32'd2, "add_carry", 32'd1);
        regs("add_carry", 32'd1, 1'b0, 1'b1);
        apply(ALU_SLL, 32'h8000_0010, 32'h0000_0024, "sll", 32'h0000_0100);
        regs("sll", 32'h0000_0100, 1'b0, 1'b0);
        apply(ALU_SRL, 32'h8000_0010, 32'h0000_0024, "srl", 32'h0800_0001);
        apply(ALU_SRA, 32'h8000_0010, 32'h0000_0024, "sra", 32'hF800_0001);
        apply(ALU_SRA, 32'h4000_0010, 32'h0000_0004, "sra_pos", 32'h0400_0001);
        apply(ALU_SLL, 32'h1234_5678, 32'h0000_0020, "sll_amt0", 32'h1234_5678);

        apply(ALU_PASSX, 32'hDEAD_BEEF, 32'h0BAD_F00D, "passx", 32'hDEAD_BEEF);
        apply(ALU_PASSY, 32'hDEAD_BEEF, 32'h0BAD_F00D, "passy", 32'h0BAD_F00D);
        regs("passy", 32'h0BAD_F00D, 1'b0, 1'b0);

        apply(ALU_ADD, 32'hFFFF_FFFF, 32'd1, "pre_illegal", 32'd0);
        regs("pre_illegal", 32'd0, 1'b1, 1'b1);
        apply(alu_operation_t'(4'hF), 32'd7, 32'd9, "illegal", 32'd0);
        regs("illegal", 32'd0, 1'b1, 1'b0);

        // Mid-stream reset, then resume.
        apply(ALU_ADD, 32'd1, 32'd1, "mid_add", 32'd2);
        rst_n = 1'b0;
        regs("mid_reset", 32'd0, 1'b0, 1'b0);
        check("mid_reset_w", w, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        regs("mid_release", 32'd2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
